// File: rtl/lsu_dmem_bridge.sv
// Load/store bridge between the core's memory stage and the data port of the
// 128 MB byte-addressed simulation memory. One request in flight at a time:
// IDLE accepts and range-checks, ACC drives a single data-port access, RSP holds
// the registered response until the core consumes it.
module lsu_dmem_bridge #(
  parameter int unsigned XLEN = 64,
  parameter logic [63:0] BASE = 64'h0000_0000_8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  // request channel
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  // response channel
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_fault,
  // data port
  output logic              dcen,
  output logic              wr,
  output logic [XLEN/8-1:0] strb,
  output logic [26:0]       daddr,
  output logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rdata,
  input  logic              error
);

  localparam int NB = int'(XLEN / 8);

  typedef enum logic [1:0] {StIdle, StAcc, StRsp} state_e;

  state_e r_state;
  state_e w_state_next;

  logic w_req_fire;
  logic w_resp_fire;
  logic w_range_fault;
  logic w_size_fault;

  // Latched request
  logic            r_wr;
  logic [1:0]      r_size;
  logic            r_unsigned;
  logic [26:0]     r_addr;
  logic [XLEN-1:0] r_wdata;
  logic            r_fault;

  // Registered response
  logic            r_resp_fault;
  logic [XLEN-1:0] r_resp_rdata;

  // Size decode and load extension
  int              w_nbytes;
  int              w_nbits;
  logic            w_sign;
  logic            w_fill;
  logic [NB-1:0]   w_strb;
  logic [XLEN-1:0] w_ext;

  assign w_req_fire  = req_valid && req_ready;
  assign w_resp_fire = resp_valid && resp_ready;

  // Window check: everything above the 27-bit offset must match the base.
  assign w_range_fault = (req_addr[XLEN-1:27] != BASE[XLEN-1:27]);
  // A doubleword only exists on a 64-bit datapath.
  assign w_size_fault  = (req_size == 2'b11) && (XLEN < 64);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: accept, one access cycle, then hold until the response is taken
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_req_fire) w_state_next = StAcc;
      StAcc:   w_state_next = StRsp;
      StRsp:   if (w_resp_fire) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Outputs decoded from state and latched request only (no input-to-output path)
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    dcen       = 1'b0;
    wr         = 1'b0;
    strb       = '0;
    daddr      = '0;
    wdata      = '0;
    unique case (r_state)
      StIdle: req_ready = 1'b1;
      StAcc: begin
        // A faulting request still spends a cycle here but never touches memory.
        dcen  = !r_fault;
        wr    = r_wr;
        strb  = w_strb;
        daddr = r_addr;
        wdata = r_wdata;
      end
      StRsp:   resp_valid = 1'b1;
      default: ;
    endcase
  end

  // Request latch: capture the transfer and its accept-time fault verdict
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr       <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_fault    <= 1'b0;
    end else if (w_req_fire) begin
      r_wr       <= req_wr;
      r_size     <= req_size;
      r_unsigned <= req_unsigned;
      r_addr     <= req_addr[26:0];
      r_wdata    <= req_wdata;
      r_fault    <= w_range_fault || w_size_fault;
    end
  end

  // Byte strobes: the low 2^size lanes, starting at daddr
  always_comb begin
    w_nbytes = 1 << r_size;
    for (int i = 0; i < NB; i++) begin
      w_strb[i] = (i < w_nbytes);
    end
  end

  // Load extension: sign bit is the top bit of the accessed width
  always_comb begin
    w_nbits = int'(XLEN);
    w_sign  = rdata[XLEN-1];
    case (r_size)
      2'b00: begin
        w_nbits = 8;
        w_sign  = rdata[7];
      end
      2'b01: begin
        w_nbits = 16;
        w_sign  = rdata[15];
      end
      2'b10: begin
        w_nbits = 32;
        w_sign  = rdata[31];
      end
      default: ;
    endcase
    w_fill = w_sign && !r_unsigned;
    for (int i = 0; i < int'(XLEN); i++) begin
      w_ext[i] = (i < w_nbits) ? rdata[i] : w_fill;
    end
  end

  // Response capture at the end of ACC; held through RSP until consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp_fault <= 1'b0;
      r_resp_rdata <= '0;
    end else if (r_state == StAcc) begin
      r_resp_fault <= r_fault || error;
      // Stores and faults return zero data.
      r_resp_rdata <= (r_fault || error || r_wr) ? '0 : w_ext;
    end
  end

  assign resp_fault = r_resp_fault;
  assign resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_lsu_dmem_bridge.sv
// Bench for lsu_dmem_bridge: emulates the byte-addressed data memory and keeps
// an independent byte-level reference memory that predicts every response.
module tb_lsu_dmem_bridge;

  localparam int          XLEN = 64;
  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
  localparam logic [63:0] WIN  = 64'd134217728;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_rdata;
  logic        resp_fault;
  logic        dcen;
  logic        wr;
  logic [7:0]  strb;
  logic [26:0] daddr;
  logic [63:0] wdata;
  logic [63:0] rdata = '0;
  logic        error = 1'b0;

  lsu_dmem_bridge #(.XLEN(XLEN), .BASE(BASE)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault),
    .dcen(dcen), .wr(wr), .strb(strb), .daddr(daddr), .wdata(wdata), .rdata(rdata),
    .error(error)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int dcen_cnt = 0;

  logic [7:0] mem     [int unsigned];
  logic [7:0] ref_mem [int unsigned];

  logic        pend_we = 1'b0;
  logic [26:0] pend_addr = '0;
  logic [7:0]  pend_strb = '0;
  logic [63:0] pend_data = '0;

  // transaction results shared by the tests
  logic [63:0] o_rd, o_awdata;
  logic        o_flt, o_adcen, o_awr;
  logic [7:0]  o_astrb;
  logic [26:0] o_adaddr;
  int          o_lat;
  bit          o_tmo;

  always @(posedge clk) cyc <= cyc + 1;

  // Data-port read side: outputs are stable mid-cycle, so the read is evaluated there.
  always @(negedge clk) begin
    logic [63:0] rd_v;
    int unsigned a;
    rd_v = '0;
    for (int i = 0; i < 8; i++) begin
      a = (32'(daddr) + 32'(i)) & 32'h07FF_FFFF;
      if (dcen && strb[i] && mem.exists(a)) rd_v[8*i +: 8] = mem[a];
    end
    rdata     = rd_v;
    pend_we   = dcen && wr;
    pend_addr = daddr;
    pend_strb = strb;
    pend_data = wdata;
    if (dcen) dcen_cnt++;
  end

  // Data-port write side: lands at the edge that ends the access cycle.
  always @(posedge clk) begin
    if (pend_we && !rst) begin
      for (int i = 0; i < 8; i++) begin
        if (pend_strb[i]) mem[(32'(pend_addr) + 32'(i)) & 32'h07FF_FFFF] = pend_data[8*i +: 8];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int unsigned off_of(input logic [63:0] a);
    return 32'((a - BASE) & (WIN - 64'd1));
  endfunction

  function automatic bit m_fault(input logic [63:0] a);
    return !(a >= BASE && a < BASE + WIN);
  endfunction

  function automatic logic [63:0] m_load(input logic [63:0] a, input logic [1:0] s,
                                         input logic u);
    int n, sh;
    int unsigned o, b;
    logic [63:0] v;
    n = 1 << s;
    o = off_of(a);
    v = '0;
    for (int i = 0; i < n; i++) begin
      b = (o + 32'(i)) & 32'h07FF_FFFF;
      if (ref_mem.exists(b)) v = v | (64'(ref_mem[b]) << (8 * i));
    end
    sh = 64 - 8 * n;
    v = v << sh;
    if (u) v = v >> sh;
    else   v = $signed(v) >>> sh;
    return v;
  endfunction

  task automatic m_store(input logic [63:0] a, input logic [1:0] s, input logic [63:0] wd);
    int n;
    int unsigned o;
    n = 1 << s;
    o = off_of(a);
    for (int i = 0; i < n; i++) ref_mem[(o + 32'(i)) & 32'h07FF_FFFF] = wd[8*i +: 8];
  endtask

  function automatic logic [7:0] mem_byte(input int unsigned a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  // One complete transaction, entered and left on a falling edge; records what it saw.
  task automatic run_req(input logic w, input logic [1:0] s, input logic u,
                         input logic [63:0] a, input logic [63:0] wd, input logic inj);
    int k;
    o_tmo = 0; o_lat = 0; o_rd = '0; o_flt = 0;
    o_adcen = 0; o_awr = 0; o_astrb = '0; o_adaddr = '0; o_awdata = '0;
    req_valid = 1; req_wr = w; req_size = s; req_unsigned = u; req_addr = a; req_wdata = wd;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) begin
      o_tmo = 1;
      req_valid = 0;
      return;
    end
    @(negedge clk);
    req_valid = 0;
    o_adcen = dcen; o_awr = wr; o_astrb = strb; o_adaddr = daddr; o_awdata = wdata;
    error = inj;
    o_lat = 1;
    do begin
      @(negedge clk);
      error = 0;
      o_lat++;
    end while (!resp_valid && o_lat < 20);
    if (!resp_valid) begin
      o_tmo = 1;
      return;
    end
    o_rd = resp_rdata; o_flt = resp_fault;
    resp_ready = 1;
    @(negedge clk);
    resp_ready = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int k;
    #1 rst = 1;
    #1;
    n_vec++;
    if ({req_ready, resp_valid, resp_fault, dcen, wr} !== 5'b10000) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b, want 10000",
               {req_ready, resp_valid, resp_fault, dcen, wr});
    end
    n_vec++;
    if ({resp_rdata, strb, daddr, wdata} !== '0) begin
      n_err++;
      $display("FAIL reset_data: got %h %h %h %h, want all zero", resp_rdata, strb, daddr, wdata);
    end
    @(negedge clk); rst = 0;
    @(negedge clk);
    req_valid = 1; req_wr = 0; req_size = 2'b11; req_unsigned = 0; req_addr = BASE + 64'h40;
    @(negedge clk);
    req_valid = 0;
    n_vec++;
    if (dcen !== 1'b1) begin
      n_err++;
      $display("FAIL reset_pre_acc: got dcen=%b, want 1", dcen);
    end
    #2 rst = 1;
    #1;
    n_vec++;
    if ({dcen, resp_valid, req_ready, strb, daddr} !== {3'b001, 8'h00, 27'h0}) begin
      n_err++;
      $display("FAIL reset_mid_acc: got dcen=%b rv=%b rr=%b strb=%h daddr=%h, want 0 0 1 0 0",
               dcen, resp_valid, req_ready, strb, daddr);
    end
    @(negedge clk); rst = 0;
    k = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid || !req_ready) k++;
    end
    n_vec++;
    if (k != 0) begin
      n_err++;
      $display("FAIL reset_no_resp: got %0d busy cycles, want 0", k);
    end
  endtask

  task automatic test_store_load();
    logic [63:0] la [8];
    logic [1:0]  ls [8];
    logic        lu [8];
    logic [63:0] le [8];
    la = '{BASE + 64'h17, BASE + 64'h10, BASE + 64'h10, BASE + 64'h16,
           BASE + 64'h14, BASE + 64'h10, BASE + 64'h12, BASE + 64'h10};
    ls = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b10, 2'b00, 2'b10, 2'b11};
    lu = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    le = '{64'h11, 64'h7788, 64'hFFFF_FFFF_FFFF_FF88, 64'h1122, 64'h1122_3344, 64'h88,
           64'h3344_5566, 64'h1122_3344_5566_7788};
    run_req(1, 2'b11, 0, 64'h8000_0010, 64'h1122_3344_5566_7788, 0);
    m_store(64'h8000_0010, 2'b11, 64'h1122_3344_5566_7788);
    n_vec++;
    if ({o_tmo, o_lat, o_flt, o_rd} !== {1'b0, 32'd2, 1'b0, 64'h0}) begin
      n_err++;
      $display("FAIL store_resp: got tmo=%b lat=%0d flt=%b rd=%h, want 0 2 0 0",
               o_tmo, o_lat, o_flt, o_rd);
    end
    n_vec++;
    if ({o_adcen, o_awr, o_astrb, o_adaddr, o_awdata} !==
        {1'b1, 1'b1, 8'hFF, 27'h10, 64'h1122_3344_5566_7788}) begin
      n_err++;
      $display("FAIL store_port: got en=%b wr=%b strb=%h addr=%h data=%h, want 1 1 ff 10 %h",
               o_adcen, o_awr, o_astrb, o_adaddr, o_awdata, 64'h1122_3344_5566_7788);
    end
    for (int i = 0; i < 8; i++) begin
      run_req(0, ls[i], lu[i], la[i], 64'h0, 0);
      n_vec++;
      if ({o_tmo, o_flt, o_rd} !== {1'b0, 1'b0, le[i]}) begin
        n_err++;
        $display("FAIL load_%0d: got tmo=%b flt=%b rd=%h, want 0 0 %h",
                 i, o_tmo, o_flt, o_rd, le[i]);
      end
    end
  endtask

  task automatic test_misaligned_wrap();
    logic [31:0] got;
    run_req(1, 2'b10, 0, 64'h87FF_FFFE, 64'h1234_5678_AABB_CCDD, 0);
    m_store(64'h87FF_FFFE, 2'b10, 64'h1234_5678_AABB_CCDD);
    n_vec++;
    if ({o_tmo, o_flt, o_adcen, o_astrb, o_adaddr} !== {1'b0, 1'b0, 1'b1, 8'h0F, 27'h7FF_FFFE})
    begin
      n_err++;
      $display("FAIL wrap_port: got tmo=%b flt=%b en=%b strb=%h addr=%h, want 0 0 1 0f 7fffffe",
               o_tmo, o_flt, o_adcen, o_astrb, o_adaddr);
    end
    got = {mem_byte(32'h1), mem_byte(32'h0), mem_byte(32'h07FF_FFFF), mem_byte(32'h07FF_FFFE)};
    n_vec++;
    if (got !== 32'hAABB_CCDD || mem.exists(32'h2)) begin
      n_err++;
      $display("FAIL wrap_bytes: got %h (byte2 written=%0d), want aabbccdd (0)",
               got, mem.exists(32'h2));
    end
    run_req(0, 2'b10, 1, 64'h87FF_FFFE, 64'h0, 0);
    n_vec++;
    if ({o_flt, o_rd} !== {1'b0, 64'h0000_0000_AABB_CCDD}) begin
      n_err++;
      $display("FAIL wrap_load_u: got flt=%b rd=%h, want 0 00000000aabbccdd", o_flt, o_rd);
    end
    run_req(0, 2'b10, 0, 64'h87FF_FFFE, 64'h0, 0);
    n_vec++;
    if ({o_flt, o_rd} !== {1'b0, 64'hFFFF_FFFF_AABB_CCDD}) begin
      n_err++;
      $display("FAIL wrap_load_s: got flt=%b rd=%h, want 0 ffffffffaabbccdd", o_flt, o_rd);
    end
  endtask

  task automatic test_fault();
    int d0;
    d0 = dcen_cnt;
    run_req(0, 2'b11, 0, 64'h7FFF_FFF8, 64'h0, 0);
    n_vec++;
    if ({o_tmo, o_lat, o_flt, o_rd, dcen_cnt - d0} !== {1'b0, 32'd2, 1'b1, 64'h0, 32'd0}) begin
      n_err++;
      $display("FAIL fault_low: got tmo=%b lat=%0d flt=%b rd=%h dcen=%0d, want 0 2 1 0 0",
               o_tmo, o_lat, o_flt, o_rd, dcen_cnt - d0);
    end
    d0 = dcen_cnt;
    run_req(1, 2'b11, 0, BASE + WIN, 64'h5A5A_5A5A_5A5A_5A5A, 0);
    n_vec++;
    if ({o_flt, o_rd, dcen_cnt - d0, mem_byte(32'h0)} !== {1'b1, 64'h0, 32'd0, 8'hBB}) begin
      n_err++;
      $display("FAIL fault_store: got flt=%b rd=%h dcen=%0d mem0=%h, want 1 0 0 bb",
               o_flt, o_rd, dcen_cnt - d0, mem_byte(32'h0));
    end
    d0 = dcen_cnt;
    run_req(0, 2'b01, 0, 64'h1_8000_0010, 64'h0, 0);
    n_vec++;
    if ({o_flt, o_rd, dcen_cnt - d0} !== {1'b1, 64'h0, 32'd0}) begin
      n_err++;
      $display("FAIL fault_high: got flt=%b rd=%h dcen=%0d, want 1 0 0",
               o_flt, o_rd, dcen_cnt - d0);
    end
    d0 = dcen_cnt;
    run_req(0, 2'b11, 0, BASE + 64'h10, 64'h0, 1);
    n_vec++;
    if ({o_flt, o_rd, dcen_cnt - d0} !== {1'b1, 64'h0, 32'd1}) begin
      n_err++;
      $display("FAIL fault_error: got flt=%b rd=%h dcen=%0d, want 1 0 1",
               o_flt, o_rd, dcen_cnt - d0);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    req_valid = 1; req_wr = 0; req_size = 2'b11; req_unsigned = 0; req_addr = BASE + 64'h10;
    bad = req_ready ? 0 : 1;
    @(negedge clk);
    // second request presented while the first is still in flight
    req_size = 2'b00; req_addr = BASE + 64'h17;
    @(negedge clk);
    repeat (5) begin
      if (!resp_valid || resp_rdata !== 64'h1122_3344_5566_7788 || resp_fault || req_ready)
        bad++;
      @(negedge clk);
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL bp_hold: got %0d unstable cycles (rv=%b rd=%h rr=%b), want 0",
               bad, resp_valid, resp_rdata, req_ready);
    end
    resp_ready = 1;
    @(negedge clk);
    resp_ready = 0;
    n_vec++;
    if ({req_ready, resp_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL bp_release: got rr=%b rv=%b, want 1 0", req_ready, resp_valid);
    end
    @(negedge clk);
    req_valid = 0;
    n_vec++;
    if ({dcen, daddr, strb} !== {1'b1, 27'h17, 8'h01}) begin
      n_err++;
      $display("FAIL bp_second_acc: got en=%b addr=%h strb=%h, want 1 17 01", dcen, daddr, strb);
    end
    @(negedge clk);
    n_vec++;
    if ({resp_valid, resp_rdata} !== {1'b1, 64'h11}) begin
      n_err++;
      $display("FAIL bp_second_resp: got rv=%b rd=%h, want 1 11", resp_valid, resp_rdata);
    end
    resp_ready = 1;
    @(negedge clk);
    resp_ready = 0;
  endtask

  task automatic test_throughput();
    logic [7:0]  st_exp [4];
    logic [63:0] a, exp_rd;
    logic [1:0]  s;
    int first, last, bad;
    st_exp = '{8'h01, 8'h03, 8'h0F, 8'hFF};
    first = 0; last = 0; bad = 0;
    resp_ready = 1;
    for (int k = 0; k < 8; k++) begin
      s = 2'(k % 4);
      a = BASE + 64'h10 + 64'(k % 3);
      exp_rd = m_load(a, s, k[2]);
      req_valid = 1; req_wr = 0; req_size = s; req_unsigned = k[2]; req_addr = a;
      if (!req_ready) bad++;
      if (k == 0) first = cyc;
      @(negedge clk);
      n_vec++;
      if ({dcen, strb} !== {1'b1, st_exp[k % 4]}) begin
        n_err++;
        $display("FAIL tput_strb_%0d: got en=%b strb=%h, want 1 %h", k, dcen, strb, st_exp[k % 4]);
      end
      @(negedge clk);
      if (!resp_valid) bad++;
      n_vec++;
      if (resp_rdata !== exp_rd) begin
        n_err++;
        $display("FAIL tput_data_%0d: got %h, want %h", k, resp_rdata, exp_rd);
      end
      last = cyc;
      @(negedge clk);
    end
    req_valid = 0;
    resp_ready = 0;
    // accept cycle through final response cycle, inclusive
    n_vec++;
    if (bad != 0 || last - first + 1 != 24) begin
      n_err++;
      $display("FAIL tput_cycles: got %0d cycles (%0d stalls), want 24 (0)",
               last - first + 1, bad);
    end
  endtask

  task automatic test_random();
    logic        w, u, inj, exp_flt;
    logic [1:0]  s;
    logic [63:0] a, wd, exp_rd;
    logic [7:0]  exp_strb;
    int r;
    for (int t = 0; t < 80; t++) begin
      w = 1'($urandom_range(0, 1));
      u = 1'($urandom_range(0, 1));
      s = 2'($urandom_range(0, 3));
      r = int'($urandom_range(0, 99));
      if (r < 8)       a = BASE - 64'($urandom_range(1, 64));
      else if (r < 12) a = {$urandom, $urandom};
      else if (r < 25) a = BASE + WIN - 64'($urandom_range(1, 8));
      else             a = BASE + 64'($urandom_range(0, 47));
      wd = {$urandom, $urandom};
      inj = !w && ($urandom_range(0, 9) == 0);
      exp_flt = m_fault(a) || inj;
      exp_rd = (exp_flt || w) ? 64'h0 : m_load(a, s, u);
      exp_strb = 8'((1 << (1 << s)) - 1);
      run_req(w, s, u, a, wd, inj);
      if (w && !m_fault(a)) m_store(a, s, wd);
      n_vec++;
      if ({o_tmo, o_lat, o_flt, o_rd} !== {1'b0, 32'd2, exp_flt, exp_rd}) begin
        n_err++;
        $display("FAIL rand_%0d_resp: got tmo=%b lat=%0d flt=%b rd=%h, want 0 2 %b %h (a=%h s=%0d)",
                 t, o_tmo, o_lat, o_flt, o_rd, exp_flt, exp_rd, a, s);
      end
      if (m_fault(a)) begin
        n_vec++;
        if (o_adcen !== 1'b0) begin
          n_err++;
          $display("FAIL rand_%0d_nodcen: got dcen=%b, want 0 (a=%h)", t, o_adcen, a);
        end
      end else begin
        n_vec++;
        if ({o_adcen, o_awr, o_astrb, o_adaddr, o_awdata} !==
            {1'b1, w, exp_strb, 27'(off_of(a)), wd}) begin
          n_err++;
          $display("FAIL rand_%0d_port: got en=%b wr=%b strb=%h addr=%h data=%h, want 1 %b %h %h %h",
                   t, o_adcen, o_awr, o_astrb, o_adaddr, o_awdata,
                   w, exp_strb, 27'(off_of(a)), wd);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_misaligned_wrap();
    test_fault();
    test_backpressure();
    test_throughput();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_dmem_bridge.md
# lsu_dmem_bridge

Load/store bridge between the core's execute/memory stage and the data port of the unified 128 MB byte-addressed simulation memory. It accepts one load or store request at a time over a valid/ready handshake and range-checks the address. It drives a single one-cycle data-port access (enable, write, byte strobes, 27-bit address, write data), captures and sign/zero-extends load data, and returns a registered response over a second valid/ready handshake.

## Interface
- XLEN, 64: data width; 32 is also legal (size 2'b11 then faults).
- BASE, 64'h0000_0000_8000_0000: base of the 128 MB window; must be 128 MB aligned.
- clk  in  1  clock; everything samples on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  bridge accepts (high only in IDLE).
- req_wr  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 double.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, right-aligned (byte 0 = lowest address).
- resp_valid  out  1  response available.
- resp_ready  in  1  core consumes the response.
- resp_rdata  out  XLEN  extended load data; 0 for stores and faults.
- resp_fault  out  1  access fault (out of window, illegal size, or memory error).
- dcen  out  1  data-port enable.
- wr  out  1  data-port write.
- strb  out  XLEN/8  byte strobes; bit i enables byte daddr+i.
- daddr  out  27  data-port byte address.
- wdata  out  XLEN  data-port write data.
- rdata  in  XLEN  data-port read data; combinational, already masked by strb.
- error  in  1  data-port error, sampled in ACC.

## Operation
- Handshakes: a request transfers when req_valid && req_ready. A response transfers when resp_valid && resp_ready.
- States and transitions:
  - IDLE → ACC on a request transfer. The request is latched: wr, size, unsigned, addr[26:0], wdata.
  - ACC → RSP unconditionally after one cycle.
  - RSP → IDLE when a response transfers.
- Fault check at accept time:
  - fault if addr[XLEN-1:27] != BASE[XLEN-1:27];
  - fault if size==11 and XLEN==32.
  - A faulting request still passes through ACC, but dcen stays 0 (no memory access).
- Memory drive, in ACC only:
  - dcen = !fault; wr = latched wr.
  - daddr = latched addr[26:0], i.e. addr - BASE.
  - strb = (1<<(1<<size))-1, so only the low 2^size bits are set.
  - wdata = latched wdata.
- All memory outputs are 0 outside ACC.
- Misaligned addresses are legal. The memory is byte-addressed, so no split is needed. daddr+i wraps modulo 2^27.
- Store: the memory writes at the ACC→RSP clock edge. resp_rdata = 0.
- Load: rdata is captured at the end of ACC.
  - Byte 2^size-1 is taken as the sign bit.
  - Bits above 8·2^size are filled with the sign bit (signed) or with 0 (unsigned).
  - For size==11, no extension is applied.
- resp_fault = latched range/size fault OR error sampled in ACC. On a fault, resp_rdata = 0.

## Timing
- Reset values:
  - state IDLE; req_ready 1; resp_valid 0; resp_rdata 0; resp_fault 0;
  - dcen 0, wr 0, strb 0, daddr 0, wdata 0.
- Request accepted at edge E0. ACC occupies the cycle after E0. resp_valid rises after E0+1, giving minimum latency 2 cycles.
- With resp_ready held high, one request completes every 3 cycles.
- resp_valid, resp_rdata and resp_fault are held stable while resp_ready=0.
- req_ready is 0 in ACC and RSP. It returns to 1 in the cycle after the response transfer; there is no same-cycle accept-on-release.
- A store is architecturally visible to any request accepted after its response.
- rst asserted mid-ACC: all outputs clear asynchronously. A store whose write edge coincides with reset assertion is not guaranteed to land. After reset the bridge is in IDLE and no response is pending.
- All outputs are registered, except that dcen, wr, strb, daddr and wdata are decoded from state plus latched registers only (no input-to-output combinational path).

## Test plan
- Reset: assert rst mid-ACC → dcen=0, resp_valid=0, req_ready=1 immediately; no response afterwards.
- Store then load:
  - store size=11, addr=0x8000_0010, wdata=0x1122334455667788.
  - load size=00 signed at 0x8000_0017 → resp_rdata=0x11.
  - load size=01 signed at 0x8000_0010 → 0xFFFF_FFFF_FFFF_8877? No: the bytes are 88,77, so expect 0x0000_0000_0000_7788.
  - load signed byte at 0x8000_0010 → 0xFFFF_FFFF_FFFF_FF88.
- Misaligned and wrap:
  - store word 0xAABBCCDD at 0x87FF_FFFE → bytes land at daddr 0x7FFFFFE, 0x7FFFFFF, 0x0, 0x1.
  - unsigned word load at the same address → 0x0000_0000_AABB_CCDD.
- Fault:
  - load at 0x7FFF_FFF8 → dcen never asserted, resp_fault=1, resp_rdata=0.
  - error forced 1 in ACC → resp_fault=1.
- Backpressure: hold resp_ready=0 for 5 cycles → response stable, req_ready=0, second request not accepted; accepted the cycle after release.
- Throughput: 8 back-to-back loads with resp_ready=1 → exactly 24 cycles from first accept to last response transfer; strb per size is 0x01, 0x03, 0x0F, 0xFF.
